// File: rtl/he_pkg.sv
// Shared types and sizing helpers for the histogram-equalization block.
package he_pkg;

    localparam int BINS = 256;

    typedef enum logic [2:0] {
        COLLECT,
        CDF,
        MAP,
        OUTPUT,
        FINISH
    } state_t;

    // Width that holds a count of 0..num_pixels without overflow.
    function automatic int cnt_w(input int num_pixels);
        return $clog2(num_pixels + 1);
    endfunction

    // Each entry holds a count first and an 8-bit table value later,
    // so it must be at least 8 bits wide even for tiny frames.
    function automatic int ent_w(input int num_pixels);
        return (cnt_w(num_pixels) > 8) ? cnt_w(num_pixels) : 8;
    endfunction

endpackage

// File: rtl/he_div.sv
// Restoring divider producing an 8-bit quotient, one bit per cycle.
// The quotient is known to fit 8 bits, so the upper numerator bits are
// preloaded as the partial remainder and only the low 8 bits are shifted in.
module he_div
    import he_pkg::*;
#(
    parameter int W = 19
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic [W+7:0]   numerator,
    input  logic [W-1:0]   denominator,
    output logic           busy,
    output logic [7:0]     quotient
);

    logic [W-1:0] rem;
    logic [7:0]   low;
    logic [2:0]   step;
    logic [W:0]   shifted;

    assign shifted = {rem, low[7]};

    // Load on start, then one restoring step per cycle for 8 cycles.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rem      <= '0;
            low      <= '0;
            step     <= '0;
            busy     <= 1'b0;
            quotient <= '0;
        end else if (start) begin
            rem      <= numerator[W+7:8];
            low      <= numerator[7:0];
            step     <= '0;
            busy     <= 1'b1;
            quotient <= '0;
        end else if (busy) begin
            if (shifted >= {1'b0, denominator}) begin
                rem      <= W'(shifted - {1'b0, denominator});
                quotient <= {quotient[6:0], 1'b1};
            end else begin
                rem      <= shifted[W-1:0];
                quotient <= {quotient[6:0], 1'b0};
            end
            low  <= {low[6:0], 1'b0};
            step <= step + 3'd1;
            if (step == 3'd7) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/he.sv
// Histogram-equalization table generator: collects one frame, builds the
// CDF in place, maps it to 0..255 and streams the 256-entry table.
//
// state   | meaning
// COLLECT | count one pixel per clock for NUM_PIXELS clocks
// CDF     | running sum over bins, one bin per clock
// MAP     | divide each cdf entry, 9 clocks per bin, plus one final write
// OUTPUT  | stream table[0..255] with done high
// FINISH  | idle until reset
module he
    import he_pkg::*;
#(
    parameter int IMAGE_WIDTH  = 660,
    parameter int IMAGE_HEIGHT = 440,
    parameter int NUM_PIXELS   = IMAGE_WIDTH * IMAGE_HEIGHT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] pixel_value,
    output logic [7:0] transformed_pixel,
    output logic       done
);

    localparam int CNT_W = cnt_w(NUM_PIXELS);
    localparam int ENT_W = ent_w(NUM_PIXELS);

    state_t             state;
    state_t             state_nxt;
    logic [ENT_W-1:0]   hist [BINS];
    logic [CNT_W-1:0]   pix_cnt;
    logic [7:0]         bin_cnt;
    logic [3:0]         div_cnt;
    logic               wr_pend;
    logic               map_tail;
    logic               div_start;
    logic               div_busy;
    logic [7:0]         div_q;
    logic [ENT_W+7:0]   div_num;

    assign div_num           = (ENT_W + 8)'(hist[bin_cnt]) * (ENT_W + 8)'(255);
    assign done              = (state == OUTPUT);
    assign transformed_pixel = done ? hist[bin_cnt][7:0] : 8'd0;

    he_div #(.W(ENT_W)) u_div (
        .clk         (clk),
        .reset       (reset),
        .start       (div_start),
        .numerator   (div_num),
        .denominator (ENT_W'(NUM_PIXELS)),
        .busy        (div_busy),
        .quotient    (div_q)
    );

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= COLLECT;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode and divider start pulse.
    always_comb begin
        state_nxt = state;
        div_start = 1'b0;
        case (state)
            COLLECT: if (pix_cnt == CNT_W'(NUM_PIXELS - 1)) state_nxt = CDF;
            CDF:     if (bin_cnt == 8'd255) state_nxt = MAP;
            MAP: begin
                div_start = (div_cnt == 4'd0) && !map_tail;
                if ((div_cnt == 4'd0) && map_tail) state_nxt = OUTPUT;
            end
            OUTPUT:  if (bin_cnt == 8'd255) state_nxt = FINISH;
            default: ;
        endcase
    end

    // Histogram/table storage and counters. A bin's quotient is written
    // while the next bin's division is being started, so MAP ends with one
    // extra cycle that stores the last entry.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < BINS; i++) begin
                hist[i] <= '0;
            end
            pix_cnt  <= '0;
            bin_cnt  <= '0;
            div_cnt  <= '0;
            wr_pend  <= 1'b0;
            map_tail <= 1'b0;
        end else begin
            case (state)
                COLLECT: begin
                    hist[pixel_value] <= hist[pixel_value] + ENT_W'(1);
                    pix_cnt           <= pix_cnt + CNT_W'(1);
                end
                CDF: begin
                    if (bin_cnt != 8'd0) begin
                        hist[bin_cnt] <= hist[bin_cnt] + hist[bin_cnt - 8'd1];
                    end
                    bin_cnt <= bin_cnt + 8'd1;
                end
                MAP: begin
                    if ((div_cnt == 4'd0) && wr_pend && !div_busy) begin
                        hist[bin_cnt - 8'd1] <= ENT_W'(div_q);
                    end
                    if ((div_cnt == 4'd0) && map_tail) begin
                        wr_pend <= 1'b0;
                    end else if (div_cnt == 4'd8) begin
                        div_cnt <= 4'd0;
                        bin_cnt <= bin_cnt + 8'd1;
                        wr_pend <= 1'b1;
                        if (bin_cnt == 8'd255) map_tail <= 1'b1;
                    end else begin
                        div_cnt <= div_cnt + 4'd1;
                    end
                end
                OUTPUT: bin_cnt <= bin_cnt + 8'd1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_he.sv
// Directed bench for he with a 4x4 frame (16 pixels).
module tb_he;

    localparam int LATENCY = 16 + 256 + 2304 + 1;

    logic       clk;
    logic       reset;
    logic [7:0] pixel_value;
    logic [7:0] transformed_pixel;
    logic       done;

    int         checks;
    int         errors;
    logic [7:0] frame_px [16];
    logic [7:0] tbl [256];
    int         rise_cyc;

    he #(.IMAGE_WIDTH(4), .IMAGE_HEIGHT(4)) dut (
        .clk               (clk),
        .reset             (reset),
        .pixel_value       (pixel_value),
        .transformed_pixel (transformed_pixel),
        .done              (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reset, stream frame_px starting in the release cycle, find the rising
    // edge of done, then capture the window. abort_k >= 0 asserts reset in
    // that window cycle and checks the outputs clear asynchronously.
    task automatic run_frame(input int abort_k);
        int n;
        int pre_bad;
        bit found;
        reset = 1'b0;
        repeat (2) @(negedge clk);
        pixel_value = frame_px[0];
        reset = 1'b1;
        n = 0;
        pre_bad = 0;
        found = 1'b0;
        rise_cyc = -1;
        while (!found && n < 3000) begin
            @(posedge clk);
            #1;
            n++;
            pixel_value = (n < 16) ? frame_px[n] : 8'h5A;
            if (done === 1'b1) begin
                found = 1'b1;
                rise_cyc = n;
            end else if (transformed_pixel !== 8'd0) begin
                pre_bad++;
            end
        end
        checks++;
        if (rise_cyc != LATENCY) begin
            errors++;
            $display("FAIL latency: done rose at cycle %0d, required %0d", rise_cyc, LATENCY);
        end
        checks++;
        if (pre_bad != 0) begin
            errors++;
            $display("FAIL pre_window_zero: %0d nonzero cycles, required 0", pre_bad);
        end
        for (int k = 0; k < 256; k++) begin
            if (k > 0) begin
                @(posedge clk);
                #1;
            end
            checks++;
            if (done !== 1'b1) begin
                errors++;
                $display("FAIL done_window[%0d]: done=%b required 1", k, done);
            end
            tbl[k] = transformed_pixel;
            if (k == abort_k) begin
                #1;
                reset = 1'b0;
                #1;
                checks++;
                if (done !== 1'b0 || transformed_pixel !== 8'd0) begin
                    errors++;
                    $display("FAIL async_reset_output: done=%b tp=%0d required 0/0", done, transformed_pixel);
                end
                return;
            end
        end
        for (int j = 0; j < 4; j++) begin
            @(posedge clk);
            #1;
            checks++;
            if (done !== 1'b0 || transformed_pixel !== 8'd0) begin
                errors++;
                $display("FAIL post_window[%0d]: done=%b tp=%0d required 0/0", j, done, transformed_pixel);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        pixel_value = 8'd33;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL reset_done: done=%b required 0", done);
        end
        checks++;
        if (transformed_pixel !== 8'd0) begin
            errors++;
            $display("FAIL reset_tp: tp=%0d required 0", transformed_pixel);
        end
    endtask

    task automatic test_all_same();
        logic [7:0] exp_v;
        for (int i = 0; i < 16; i++) frame_px[i] = 8'd100;
        run_frame(-1);
        for (int k = 0; k < 256; k++) begin
            exp_v = (k < 100) ? 8'd0 : 8'd255;
            checks++;
            if (tbl[k] !== exp_v) begin
                errors++;
                $display("FAIL all_100 table[%0d]: got %0d required %0d", k, tbl[k], exp_v);
            end
        end
    endtask

    task automatic test_ramp();
        logic [7:0] exp_v;
        for (int i = 0; i < 16; i++) frame_px[i] = 8'(i);
        run_frame(-1);
        for (int k = 0; k < 256; k++) begin
            exp_v = (k < 16) ? 8'(((k + 1) * 255) / 16) : 8'd255;
            checks++;
            if (tbl[k] !== exp_v) begin
                errors++;
                $display("FAIL ramp table[%0d]: got %0d required %0d", k, tbl[k], exp_v);
            end
        end
        checks++;
        if (tbl[0] !== 8'd15 || tbl[7] !== 8'd127 || tbl[15] !== 8'd255) begin
            errors++;
            $display("FAIL ramp_points: got %0d/%0d/%0d required 15/127/255", tbl[0], tbl[7], tbl[15]);
        end
    endtask

    task automatic test_split();
        logic [7:0] exp_v;
        for (int i = 0; i < 16; i++) frame_px[i] = (i < 8) ? 8'd0 : 8'd255;
        run_frame(-1);
        for (int k = 0; k < 256; k++) begin
            exp_v = (k < 255) ? 8'd127 : 8'd255;
            checks++;
            if (tbl[k] !== exp_v) begin
                errors++;
                $display("FAIL split table[%0d]: got %0d required %0d", k, tbl[k], exp_v);
            end
        end
    endtask

    task automatic test_reset_mid_collect();
        logic [7:0] exp_v;
        reset = 1'b0;
        repeat (2) @(negedge clk);
        pixel_value = 8'd50;
        reset = 1'b1;
        repeat (7) @(negedge clk);
        for (int i = 0; i < 16; i++) frame_px[i] = 8'd200;
        run_frame(-1);
        for (int k = 0; k < 256; k++) begin
            exp_v = (k < 200) ? 8'd0 : 8'd255;
            checks++;
            if (tbl[k] !== exp_v) begin
                errors++;
                $display("FAIL mid_collect table[%0d]: got %0d required %0d", k, tbl[k], exp_v);
            end
        end
    endtask

    task automatic test_reset_in_output();
        for (int i = 0; i < 16; i++) frame_px[i] = 8'd7;
        run_frame(20);
        checks++;
        if (tbl[20] !== 8'd255 || tbl[3] !== 8'd0) begin
            errors++;
            $display("FAIL pre_abort_values: got %0d/%0d required 255/0", tbl[20], tbl[3]);
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (done !== 1'b0 || transformed_pixel !== 8'd0) begin
            errors++;
            $display("FAIL held_in_reset: done=%b tp=%0d required 0/0", done, transformed_pixel);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset = 1'b0;
        pixel_value = 8'd0;
        test_reset();
        test_all_same();
        test_ramp();
        test_split();
        test_reset_mid_collect();
        test_reset_in_output();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/he.md
HE -- requirements
Module: he

Interface
REQ-001 Parameter IMAGE_WIDTH, default 660, image width in pixels.
REQ-002 Parameter IMAGE_HEIGHT, default 440, image height in pixels.
REQ-003 Parameter NUM_PIXELS, default IMAGE_WIDTH*IMAGE_HEIGHT, number of pixels per frame.
REQ-004 Port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-005 Port reset, input, 1 bit, asynchronous active-low reset.
REQ-006 Port pixel_value, input, 8 bits, one pixel intensity sampled every clock during collection.
REQ-007 Port transformed_pixel, output, 8 bits, equalization table entry streamed during output.
REQ-008 Port done, output, 1 bit, high while the table stream is valid.

Function
REQ-009 The block SHALL compute a histogram-equalization mapping table for one frame and stream its 256 entries out.
REQ-010 The FSM SHALL have the states COLLECT, CDF, MAP, OUTPUT and FINISH, in that order.
REQ-011 COLLECT: increment hist[pixel_value] on every clock for exactly NUM_PIXELS clocks, starting on the first rising edge after reset release.
- No valid strobe.
- Back-to-back equal values SHALL count correctly, because the histogram is a register array updated in the same cycle.
REQ-012 Counter width SHALL be CNT_W = clog2(NUM_PIXELS+1), which is 19 bits at the defaults, so no count can overflow.
REQ-013 CDF: 256 cycles, one bin per cycle, ascending; replace hist[k] in place by cdf[k] = sum of hist[0..k].
REQ-014 MAP: for k = 0..255, table[k] SHALL equal floor(cdf[k]*255 / NUM_PIXELS).
- Computed by an iterative restoring divider producing 1 quotient bit per cycle.
- 8 quotient bits plus 1 load cycle gives 9 cycles per entry.
- The result is stored in place, using the low 8 bits of the entry.
REQ-015 The numerator SHALL be CNT_W+8 bits wide; the quotient never exceeds 255 and SHALL NOT saturate.
REQ-016 OUTPUT: done SHALL be high for exactly 256 consecutive cycles.
- In the k-th cycle (k = 0..255) of that window, transformed_pixel = table[k].
REQ-017 FINISH: done=0 and transformed_pixel=0; the FSM holds in FINISH until the next reset.
REQ-018 Outside OUTPUT, transformed_pixel SHALL be 0 and done SHALL be 0.
REQ-019 pixel_value SHALL be ignored in every state except COLLECT.
REQ-020 Latency SHALL be fixed: done rises exactly NUM_PIXELS + 256 + 256*9 + 1 cycles after the first collected pixel.

Reset
REQ-021 While reset=0, the following SHALL be cleared asynchronously:
- all histogram/table entries and the pixel, bin and divider counters;
- transformed_pixel=0 and done=0;
- FSM state = COLLECT.
REQ-022 Assertion of reset in any state, including mid-COLLECT or mid-OUTPUT, SHALL abort the frame; after release, a new frame starts from pixel 0.

Structure
REQ-023 A shared package SHALL hold the state enum, the constant BINS=256 and the function computing CNT_W.
REQ-024 The divider SHALL be one sub-module, he_div, with start/busy/quotient handshake.
- start is a 1-cycle pulse that latches the numerator.
- quotient is valid when busy falls, 9 cycles after start.
REQ-025 Histogram storage, counters and the FSM SHALL reside in he.

Verification (use IMAGE_WIDTH=4, IMAGE_HEIGHT=4, so NUM_PIXELS=16)
REQ-026 Sixteen pixels all = 100 -> table[0..99] = 0 and table[100..255] = 255.
REQ-027 Pixels 0,1,...,15 -> table[k] = floor((k+1)*255/16), so table[0]=15, table[7]=127, table[15]=255 and table[16..255]=255.
REQ-028 Eight pixels of 0, then eight of 255 -> table[0..254] = 127 and table[255] = 255.
REQ-029 Any frame -> done rises exactly 16+256+2304+1 cycles after the first pixel, stays high for 256 cycles, then stays low; transformed_pixel = 0 outside the window.
REQ-030 Reset pulsed after 7 pixels, then 16 pixels all = 200 -> the result matches the all-200 frame only: table[199]=0 and table[200]=255.
REQ-031 Reset asserted during OUTPUT -> done=0 and transformed_pixel=0 immediately (asynchronously).
